// File: rtl/fractal_colorizer.sv
// Iteration-count to RGB colouriser: palette lookup, output FIFO and frame resync on overflow.
// Pixels dropped on a full FIFO force a wait for the next frame start so positions never shift.
module fractal_colorizer #(
  parameter int FIFO_DEPTH = 32,
  parameter int LEVEL_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_frame_start,
  input  logic               in_line_end,
  input  logic               in_valid,
  input  logic               pal_we,
  input  logic [7:0]         pal_addr,
  input  logic [23:0]        pal_wdata,
  input  logic               overflow_clr,
  output logic [23:0]        m_tdata,
  output logic               m_tuser,
  output logic               m_tlast,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               overflow,
  output logic [LEVEL_W-1:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {WAIT_SOF, RUN} state_t;

  // Stage 1: palette address plus qualified flags
  logic [7:0] s1_addr;
  logic       s1_valid, s1_sof, s1_eol;

  always_ff @(posedge clk) begin
    s1_addr <= in_data;
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_sof   <= in_valid && in_frame_start;
      s1_eol   <= in_valid && in_line_end;
    end
  end

  // Palette RAM, read-first. Entries never written read back as grayscale {i,i,i}.
  logic [23:0]  pal_mem [256];
  logic [255:0] pal_written = '0;
  logic [23:0]  pal_rd_mem;
  logic         pal_rd_written;
  logic [7:0]   pal_rd_addr;

  always_ff @(posedge clk) begin
    if (pal_we) begin
      pal_mem[pal_addr] <= pal_wdata;
    end
    pal_rd_mem <= pal_mem[s1_addr];
  end

  always_ff @(posedge clk) begin
    if (pal_we) begin
      pal_written[pal_addr] <= 1'b1;
    end
    pal_rd_written <= pal_written[s1_addr];
    pal_rd_addr    <= s1_addr;
  end

  // Stage 2: write request toward the FIFO
  logic        s2_valid, s2_sof, s2_eol;
  logic [23:0] s2_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
    end
  end

  assign s2_data = pal_rd_written ? pal_rd_mem : {3{pal_rd_addr}};

  // First-word-fall-through FIFO
  logic [25:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic [25:0]        head;
  logic               full, pop, can_write, push, drop;
  state_t             state;

  assign full      = (count == LEVEL_W'(FIFO_DEPTH));
  assign m_tvalid  = (count != '0);
  assign pop       = m_tvalid && m_tready;
  assign can_write = !full || pop;

  always_comb begin
    push = 1'b0;
    drop = 1'b0;
    if (s2_valid && (state == RUN || s2_sof)) begin
      if (can_write) begin
        push = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_SOF;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        state <= WAIT_SOF;
      end else if (push) begin
        state <= RUN;
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s2_sof, s2_eol, s2_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + LEVEL_W'(push) - LEVEL_W'(pop);
    end
  end

  // Head slot cannot be overwritten while held: a full-FIFO write only lands on it during its pop
  assign head       = fifo_mem[rd_ptr];
  assign m_tdata    = m_tvalid ? head[23:0] : 24'd0;
  assign m_tlast    = m_tvalid && head[24];
  assign m_tuser    = m_tvalid && head[25];
  assign fifo_level = count;

endmodule

// File: doc/fractal_colorizer.md
Name: fractal_colorizer

Overview:
- Sits directly downstream of the fractal generator. Consumes its 8-bit iteration-count pixel stream (tdata/tuser/tlast/tvalid, no backpressure).
- Maps each count through a software-programmable 256-entry RGB palette.
- Buffers the result in a FIFO and presents it as an AXI4-Stream video master with tready backpressure toward the VDMA.
- When the FIFO overflows, drops pixels and resynchronises on the next frame start, so a partial frame never shifts pixel positions.

Parameters:
- FIFO_DEPTH, 32, output FIFO entries; must be a power of two, ≥4.
- LEVEL_W, 6, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  iteration count (generator tdata).
- in_frame_start  input  1  first pixel of frame (generator tuser); qualified by in_valid.
- in_line_end  input  1  last pixel of line (generator tlast); qualified by in_valid.
- in_valid  input  1  pixel present this cycle; no ready is returned.
- pal_we  input  1  palette write strobe.
- pal_addr  input  8  palette write address.
- pal_wdata  input  24  palette entry, stored and emitted verbatim.
- overflow_clr  input  1  clears the sticky overflow flag.
- m_tdata  output  24  colour pixel.
- m_tuser  output  1  start of frame.
- m_tlast  output  1  end of line.
- m_tvalid  output  1  output valid.
- m_tready  input  1  downstream ready.
- overflow  output  1  sticky; set on any dropped pixel.
- fifo_level  output  LEVEL_W  current FIFO occupancy.

Behaviour:

Reset:
- m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, overflow=0, fifo_level=0.
- FIFO is emptied and all pipeline valids are cleared.
- The state machine enters WAIT_SOF.
- Palette contents are NOT affected by reset. The power-up initial value is grayscale: entry i = {i,i,i}.

Palette:
- Single write port and one synchronous read port.
- A write and a read of the same address in the same cycle return the OLD entry (read-first). The new entry is visible from the next cycle.
- Writes are accepted at any time, including mid-frame; pixels read afterwards use the new colour.

Pipeline:
- Stage 1 registers in_data as the palette address, together with in_valid, in_frame_start and in_line_end.
- Stage 2 takes the palette read data plus the delayed flags; this is the FIFO write request.
- The FIFO is first-word-fall-through. m_tvalid rises the cycle after the first write into an empty FIFO.
- Minimum latency from in_valid to m_tvalid is 3 cycles.

FIFO:
- A write is accepted if the FIFO is not full, OR if it is full and a pop (m_tvalid && m_tready) occurs in the same cycle.
- fifo_level = writes − pops, updated every cycle; a simultaneous push and pop leaves it unchanged.
- m_tdata, m_tuser and m_tlast are held stable while m_tvalid && !m_tready.

State machine (evaluated on the stage-2 write request):
- WAIT_SOF: discard pixels until one arrives with frame_start=1. That pixel is written (subject to the overflow rule) and the state moves to RUN.
- RUN: write every valid pixel. If a write is rejected because the FIFO is full:
  - the pixel is dropped;
  - overflow is set;
  - the state moves to WAIT_SOF.
- Rejected frame-start pixel in WAIT_SOF: drop it, set overflow, stay in WAIT_SOF.

Overflow flag:
- Once set, remains set until reset or overflow_clr.
- If a set event and overflow_clr occur in the same cycle, set wins.

Other rules:
- Pixels already in the FIFO at a drop are still drained normally.
- Reset asserted mid-frame or mid-burst discards FIFO contents immediately; m_tvalid is 0 the cycle after reset is sampled.
- in_frame_start and in_line_end are ignored when in_valid=0.

Test Plan:
1. Reset, default palette, m_tready=1; feed a 4x2 frame with counts 0..7 (SOF on pixel 0, tlast on pixels 3 and 7) -> m_tdata 0x000000, 0x010101 ... 0x070707. m_tuser only on the first beat, m_tlast on beats 4 and 8, first m_tvalid 3 cycles after the first in_valid.
2. Before the frame starts, write pal_addr=5, pal_wdata=0xFF8000. Stream count 5 -> 0xFF8000. Then write pal_addr=5 in the same cycle that count 5 sits in stage 1 -> that pixel still yields 0xFF8000 (read-first).
3. Pixels arriving before any SOF after reset -> no output and overflow=0. Output begins exactly at the SOF pixel.
4. FIFO_DEPTH=32, m_tready=0, stream 40 pixels of one frame -> fifo_level=32 and overflow=1. Then m_tready=1 -> exactly 32 beats drain. Later pixels of that frame are discarded; the next frame's SOF pixel is emitted with m_tuser=1.
5. FIFO full, m_tready=1 and a new pixel arriving in the same cycle -> write accepted, fifo_level stays 32, overflow stays 0.
6. overflow=1, then overflow_clr pulses -> overflow=0 next cycle. An overflow_clr coincident with a new drop -> overflow stays 1.
